// File: rtl/msrv32_ahb_pkg.sv
// Shared types for the msrv32 AHB-Lite fetch/data arbiter.
// Transfer encodings, FSM states and bus-owner tags.
package msrv32_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA
  } state_e;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_e;

  // Malformed masks fall back to a word transfer.
  function automatic logic [2:0] mask_to_hsize(input logic [3:0] m);
    logic [2:0] s;
    case (m)
      4'b0011, 4'b1100: s = HSIZE_HALF;
      4'b0001, 4'b0010,
      4'b0100, 4'b1000: s = HSIZE_BYTE;
      default:          s = HSIZE_WORD;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/msrv32_arb_select.sv
// Fetch/data tie-break: data priority with a starvation guard,
// or round-robin against the last grantee.
import msrv32_ahb_pkg::*;

module msrv32_arb_select #(
  parameter bit          DATA_PRIORITY = 1'b1,
  parameter int unsigned MAX_D_STREAK  = 4
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   i_req_i,
  input  logic   d_req_i,
  input  logic   gnt_i,
  output owner_e winner_o
);

  localparam logic [3:0] MAX_S = 4'(MAX_D_STREAK);

  logic [3:0] streak_q, streak_d;
  owner_e     last_q, last_d;

  always_comb begin
    winner_o = OWN_I;
    if (i_req_i && d_req_i) begin
      if (DATA_PRIORITY)
        winner_o = (streak_q == MAX_S) ? OWN_I : OWN_D;
      else
        winner_o = (last_q == OWN_I) ? OWN_D : OWN_I;
    end else if (d_req_i) begin
      winner_o = OWN_D;
    end
  end

  // Streak only grows while fetch is actually being held off.
  always_comb begin
    streak_d = streak_q;
    last_d   = last_q;
    if (gnt_i) begin
      last_d = winner_o;
      if (winner_o == OWN_D && i_req_i)
        streak_d = (streak_q == MAX_S) ? MAX_S : streak_q + 4'd1;
      else
        streak_d = 4'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      streak_q <= 4'd0;
      last_q   <= OWN_I;
    end else begin
      streak_q <= streak_d;
      last_q   <= last_d;
    end
  end

endmodule

// File: rtl/msrv32_ahb_arbiter.sv
// Single AHB-Lite master shared by msrv32 fetch and load/store.
// One outstanding single transfer: NONSEQ then IDLE.
import msrv32_ahb_pkg::*;

module msrv32_ahb_arbiter #(
  parameter bit          DATA_PRIORITY = 1'b1,
  parameter int unsigned MAX_D_STREAK  = 4
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        i_req_in,
  input  logic [31:0] i_addr_in,
  output logic        i_gnt_out,
  output logic        i_ready_out,
  output logic [31:0] i_rdata_out,
  input  logic        d_req_in,
  input  logic [31:0] d_addr_in,
  input  logic        d_we_in,
  input  logic [31:0] d_wdata_in,
  input  logic [3:0]  d_mask_in,
  output logic        d_gnt_out,
  output logic        d_ready_out,
  output logic [31:0] d_rdata_out,
  output logic        d_err_out,
  output logic [31:0] haddr_out,
  output logic [1:0]  htrans_out,
  output logic        hwrite_out,
  output logic [2:0]  hsize_out,
  output logic [31:0] hwdata_out,
  input  logic [31:0] hrdata_in,
  input  logic        hready_in,
  input  logic        hresp_in
);

  logic clk, rst;
  assign clk = ms_riscv32_mp_clk_in;
  assign rst = ms_riscv32_mp_rst_in;

  state_e      state_q, state_d;
  owner_e      own_q, own_d, winner;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [2:0]  size_q, size_d;
  logic        any_req, grant;

  assign any_req = i_req_in | d_req_in;
  assign grant   = (state_q == ST_IDLE) & any_req & ~rst;

  msrv32_arb_select #(
    .DATA_PRIORITY(DATA_PRIORITY),
    .MAX_D_STREAK (MAX_D_STREAK)
  ) u_sel (
    .clk_i   (clk),
    .rst_i   (rst),
    .i_req_i (i_req_in),
    .d_req_i (d_req_in),
    .gnt_i   (grant),
    .winner_o(winner)
  );

  always_comb begin
    state_d     = state_q;
    own_d       = own_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    size_d      = size_q;
    i_gnt_out   = 1'b0;
    i_ready_out = 1'b0;
    i_rdata_out = 32'd0;
    d_gnt_out   = 1'b0;
    d_ready_out = 1'b0;
    d_rdata_out = 32'd0;
    d_err_out   = 1'b0;
    haddr_out   = 32'd0;
    htrans_out  = HTRANS_IDLE;
    hwrite_out  = 1'b0;
    hsize_out   = HSIZE_BYTE;
    hwdata_out  = 32'd0;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_ADDR;
          own_d   = winner;
          if (winner == OWN_D) begin
            addr_d    = d_addr_in;
            we_d      = d_we_in;
            wdata_d   = d_wdata_in;
            size_d    = mask_to_hsize(d_mask_in);
            d_gnt_out = grant;
          end else begin
            addr_d    = i_addr_in;
            we_d      = 1'b0;
            wdata_d   = 32'd0;
            size_d    = HSIZE_WORD;
            i_gnt_out = grant;
          end
        end
      end
      ST_ADDR: begin
        htrans_out = HTRANS_NONSEQ;
        haddr_out  = addr_q;
        hwrite_out = we_q;
        hsize_out  = size_q;
        if (hready_in) state_d = ST_DATA;
      end
      ST_DATA: begin
        hwdata_out = we_q ? wdata_q : 32'd0;
        if (hready_in) begin
          state_d = ST_IDLE;
          // A transfer cut short by reset must not complete.
          if (!rst) begin
            if (own_q == OWN_D) begin
              d_ready_out = 1'b1;
              d_rdata_out = hrdata_in;
              d_err_out   = hresp_in;
            end else begin
              i_ready_out = 1'b1;
              i_rdata_out = hrdata_in;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      own_q   <= OWN_I;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      size_q  <= HSIZE_BYTE;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      size_q  <= size_d;
    end
  end

endmodule

// File: tb/tb_msrv32_ahb_arbiter.sv
// Bench for msrv32_ahb_arbiter: cycle vectors, arbitration
// order sequences and a random run against a transfer model.
module tb_msrv32_ahb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ireq = 1'b0, dreq = 1'b0, dwe = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dwdata = '0, hrdata = '0;
  logic [3:0]  dmask = '0;
  logic        hready = 1'b0, hresp = 1'b0;

  logic        ig, ir, dg, dr, de, hwrite;
  logic [31:0] ird, drd, haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;

  logic        r_ig, r_ir, r_dg, r_dr, r_de, r_hwrite;
  logic [31:0] r_ird, r_drd, r_haddr, r_hwdata;
  logic [1:0]  r_htrans;
  logic [2:0]  r_hsize;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  msrv32_ahb_arbiter dut (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst),
    .i_req_in(ireq), .i_addr_in(iaddr), .i_gnt_out(ig),
    .i_ready_out(ir), .i_rdata_out(ird),
    .d_req_in(dreq), .d_addr_in(daddr), .d_we_in(dwe),
    .d_wdata_in(dwdata), .d_mask_in(dmask), .d_gnt_out(dg),
    .d_ready_out(dr), .d_rdata_out(drd), .d_err_out(de),
    .haddr_out(haddr), .htrans_out(htrans), .hwrite_out(hwrite),
    .hsize_out(hsize), .hwdata_out(hwdata), .hrdata_in(hrdata),
    .hready_in(hready), .hresp_in(hresp)
  );

  msrv32_ahb_arbiter #(.DATA_PRIORITY(1'b0)) dut_rr (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst),
    .i_req_in(ireq), .i_addr_in(iaddr), .i_gnt_out(r_ig),
    .i_ready_out(r_ir), .i_rdata_out(r_ird),
    .d_req_in(dreq), .d_addr_in(daddr), .d_we_in(dwe),
    .d_wdata_in(dwdata), .d_mask_in(dmask), .d_gnt_out(r_dg),
    .d_ready_out(r_dr), .d_rdata_out(r_drd), .d_err_out(r_de),
    .haddr_out(r_haddr), .htrans_out(r_htrans), .hwrite_out(r_hwrite),
    .hsize_out(r_hsize), .hwdata_out(r_hwdata), .hrdata_in(hrdata),
    .hready_in(hready), .hresp_in(hresp)
  );

  localparam logic [4:0] F_IG = 5'b10000;
  localparam logic [4:0] F_IR = 5'b01000;
  localparam logic [4:0] F_DG = 5'b00100;
  localparam logic [4:0] F_DR = 5'b00010;
  localparam logic [4:0] F_DE = 5'b00001;
  localparam int MAXS = 4;

  typedef struct {
    logic        rst, ireq, dreq, dwe, hready, hresp;
    logic [31:0] iaddr, daddr, dwdata, hrdata;
    logic [3:0]  dmask;
    logic [4:0]  f;
    logic [31:0] ha, wd, rd;
    logic [1:0]  ht;
    logic        hw;
    logic [2:0]  hs;
  } vec_t;

  vec_t vq[$];

  function automatic logic [159:0] pk(
    input logic [4:0] f, input logic [31:0] ha, input logic [1:0] ht,
    input logic hw, input logic [2:0] hs, input logic [31:0] wd,
    input logic [31:0] a, input logic [31:0] b);
    return {21'd0, f, ha, ht, hw, hs, wd, a, b};
  endfunction

  function automatic logic [159:0] act();
    return pk({ig, ir, dg, dr, de}, haddr, htrans, hwrite, hsize,
              hwdata, ird, drd);
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [159:0] a, input logic [159:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s[%0d] got=%h exp=%h", nm, idx, a, e);
    end
  endtask

  task automatic push(input logic [4:0] f, input logic [31:0] ha,
                      input logic [1:0] ht, input logic hw,
                      input logic [2:0] hs, input logic [31:0] wd,
                      input logic [31:0] rd);
    vec_t v;
    v.rst = rst; v.ireq = ireq; v.dreq = dreq; v.dwe = dwe;
    v.hready = hready; v.hresp = hresp; v.iaddr = iaddr;
    v.daddr = daddr; v.dwdata = dwdata; v.hrdata = hrdata;
    v.dmask = dmask; v.f = f; v.ha = ha; v.wd = wd; v.rd = rd;
    v.ht = ht; v.hw = hw; v.hs = hs;
    vq.push_back(v);
  endtask

  task automatic do_reset();
    rst = 1'b1; ireq = 1'b0; dreq = 1'b0; hready = 1'b1; hresp = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Transfer-level reference: one in-flight record plus a data-run count.
  bit          m_busy, m_dphase, m_d, m_we;
  logic [31:0] m_addr, m_wd;
  logic [2:0]  m_sz;
  int          m_run;

  function automatic logic [2:0] ref_size(input logic [3:0] m);
    if ($countones(m) == 1) return 3'b000;
    if (m == 4'h3 || m == 4'hC) return 3'b001;
    return 3'b010;
  endfunction

  initial begin
    byte g1[$], g2[$];
    string e1, e2;
    bit igot, dgot;
    logic [3:0] masks [8];
    masks = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'h6};

    // Vector table: one entry per cycle.
    rst = 1; push(0, 0, 0, 0, 0, 0, 0);
    rst = 0; hready = 1; ireq = 1; iaddr = 32'h100; hrdata = 32'h13;
    push(F_IG, 0, 0, 0, 0, 0, 0);
    ireq = 0; push(0, 32'h100, 2'b10, 0, 3'b010, 0, 0);
    push(F_IR, 0, 0, 0, 0, 0, 32'h13);
    dreq = 1; dwe = 1; daddr = 32'h2003; dmask = 4'b1000;
    dwdata = 32'hAB00_0000; hrdata = 32'h55;
    push(F_DG, 0, 0, 0, 0, 0, 0);
    dreq = 0; push(0, 32'h2003, 2'b10, 1, 3'b000, 0, 0);
    push(F_DR, 0, 0, 0, 0, 32'hAB00_0000, 32'h55);
    ireq = 1; iaddr = 32'h200; hrdata = 32'hCAFE;
    push(F_IG, 0, 0, 0, 0, 0, 0);
    ireq = 0; hready = 0;
    for (int k = 0; k < 3; k++) push(0, 32'h200, 2'b10, 0, 3'b010, 0, 0);
    hready = 1; push(0, 32'h200, 2'b10, 0, 3'b010, 0, 0);
    hready = 0;
    for (int k = 0; k < 2; k++) push(0, 0, 0, 0, 0, 0, 0);
    hready = 1; push(F_IR, 0, 0, 0, 0, 0, 32'hCAFE);
    ireq = 1; iaddr = 32'h300; dreq = 1; dwe = 0; daddr = 32'h1002;
    dmask = 4'hC; hrdata = 32'h77;
    push(F_DG, 0, 0, 0, 0, 0, 0);
    dreq = 0; push(0, 32'h1002, 2'b10, 0, 3'b001, 0, 0);
    hresp = 1; push(F_DR | F_DE, 0, 0, 0, 0, 0, 32'h77);
    hresp = 0; push(F_IG, 0, 0, 0, 0, 0, 0);
    ireq = 0; push(0, 32'h300, 2'b10, 0, 3'b010, 0, 0);
    push(F_IR, 0, 0, 0, 0, 0, 32'h77);
    dreq = 1; dwe = 1; daddr = 32'h5; dmask = 4'b0110; dwdata = 32'h1234;
    push(F_DG, 0, 0, 0, 0, 0, 0);
    dreq = 0; push(0, 32'h5, 2'b10, 1, 3'b010, 0, 0);
    push(F_DR, 0, 0, 0, 0, 32'h1234, 32'h77);
    dreq = 1; dwe = 0; daddr = 32'h40; dmask = 4'hF;
    push(F_DG, 0, 0, 0, 0, 0, 0);
    dreq = 0; rst = 1; push(0, 32'h40, 2'b10, 0, 3'b010, 0, 0);
    rst = 0; push(0, 0, 0, 0, 0, 0, 0);
    push(0, 0, 0, 0, 0, 0, 0);

    do_reset();
    rst = 1'b1;
    for (int i = 0; i < vq.size(); i++) begin
      rst = vq[i].rst; ireq = vq[i].ireq; dreq = vq[i].dreq;
      dwe = vq[i].dwe; hready = vq[i].hready; hresp = vq[i].hresp;
      iaddr = vq[i].iaddr; daddr = vq[i].daddr; dwdata = vq[i].dwdata;
      hrdata = vq[i].hrdata; dmask = vq[i].dmask;
      @(negedge clk);
      chk("vec", i, act(),
          pk(vq[i].f, vq[i].ha, vq[i].ht, vq[i].hw, vq[i].hs, vq[i].wd,
             (vq[i].f & F_IR) != 0 ? vq[i].rd : 32'd0,
             (vq[i].f & F_DR) != 0 ? vq[i].rd : 32'd0));
      @(posedge clk); #1;
    end

    // Both requesters held: priority and round-robin grant order.
    do_reset();
    ireq = 1; dreq = 1; dwe = 0; dmask = 4'hF; hready = 1;
    for (int c = 0; c < 80 && (g1.size() < 10 || g2.size() < 10); c++) begin
      @(negedge clk);
      if (ig) g1.push_back("I");
      if (dg) g1.push_back("D");
      if (r_ig) g2.push_back("I");
      if (r_dg) g2.push_back("D");
    end
    e1 = "DDDDIDDDDI";
    e2 = "DIDIDIDIDI";
    for (int k = 0; k < 10; k++) begin
      chk("prio_order", k, (k < g1.size()) ? 160'(g1[k]) : 160'd0,
          160'(e1[k]));
      chk("rr_order", k, (k < g2.size()) ? 160'(g2[k]) : 160'd0,
          160'(e2[k]));
    end
    @(posedge clk); #1;

    // Randomized traffic against the transfer-level model.
    do_reset();
    m_busy = 0; m_dphase = 0; m_run = 0; igot = 0; dgot = 0;
    for (int c = 0; c < 3000; c++) begin
      logic [4:0]  f;
      logic [31:0] eha, ewd, eird, edrd;
      logic [1:0]  eht;
      logic        ehw;
      logic [2:0]  ehs;
      if (!ireq || igot) begin
        ireq = ($urandom_range(0, 2) != 0); iaddr = $urandom;
      end
      if (!dreq || dgot) begin
        dreq = ($urandom_range(0, 2) != 0); daddr = $urandom;
        dwe = 1'($urandom); dwdata = $urandom;
        dmask = masks[$urandom_range(0, 7)];
      end
      hready = ($urandom_range(0, 3) != 0);
      hresp = ($urandom_range(0, 3) == 0);
      hrdata = $urandom;
      @(negedge clk);
      f = 0; eha = 0; ewd = 0; eird = 0; edrd = 0; eht = 0; ehw = 0; ehs = 0;
      igot = 0; dgot = 0;
      if (!m_busy) begin
        if (ireq || dreq) begin
          m_d = dreq && !(ireq && m_run >= MAXS);
          if (m_d) begin
            f = F_DG; dgot = 1; m_addr = daddr; m_we = dwe;
            m_wd = dwdata; m_sz = ref_size(dmask);
            m_run = ireq ? ((m_run + 1 > MAXS) ? MAXS : m_run + 1) : 0;
          end else begin
            f = F_IG; igot = 1; m_addr = iaddr; m_we = 0;
            m_wd = 0; m_sz = 3'b010; m_run = 0;
          end
          m_busy = 1; m_dphase = 0;
        end
      end else if (!m_dphase) begin
        eht = 2'b10; eha = m_addr; ehw = m_we; ehs = m_sz;
        if (hready) m_dphase = 1;
      end else begin
        ewd = m_we ? m_wd : 32'd0;
        if (hready) begin
          if (m_d) begin
            f = hresp ? (F_DR | F_DE) : F_DR; edrd = hrdata;
          end else begin
            f = F_IR; eird = hrdata;
          end
          m_busy = 0;
        end
      end
      chk("rand", c, act(), pk(f, eha, eht, ehw, ehs, ewd, eird, edrd));
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
